mc_histogram_accum: RTL and testbench

MC_HISTOGRAM_ACCUM -- requirements
Module: mc_histogram_accum

---
 rtl/mc_histogram_accum.sv | 126 ++++++++++++
 tb/tb_mc_histogram_accum.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mc_histogram_accum.sv
// Multi-channel histogram accumulator: one RAM bank per channel, 2-stage read-modify-write
// with same-bin forwarding, zeroing sweep, readout port. Define HIST_SATURATE_EN to saturate.
module mc_histogram_accum #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 24,
    localparam int unsigned CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_bin,
    output logic                         o_ready,
    input  logic                         i_rd_req,
    input  logic [CH_WIDTH-1:0]          i_rd_ch,
    input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
    output logic                         o_rd_valid,
    output logic [CNT_WIDTH-1:0]         o_rd_data,
    output logic                         o_clear_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef enum logic [0:0] {StClear, StAccum} state_e;

    state_e state_q, state_d;
    addr_t  sweep_q, sweep_d;

    cnt_t   mem [NUM_CH][DEPTH];
    addr_t  bin_in    [NUM_CH];
    addr_t  s2_bin_q  [NUM_CH];
    cnt_t   s2_base_q [NUM_CH];
    cnt_t   s2_wdata  [NUM_CH];
    logic   upd_v_q;
    logic   rd_valid_q;
    cnt_t   rd_data_q;
    cnt_t   rd_next;

    logic upd_acc, rd_acc, upd_we, clear_we, rd_fwd;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StClear: begin
                if (i_clear) begin
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == '1) state_d = StAccum;
                end
            end
            StAccum: begin
                if (i_clear) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
        endcase
    end

    assign o_ready      = (state_q == StAccum);
    assign o_clear_busy = (state_q == StClear);

    // i_clear squashes anything accepted in the same cycle and the pending stage-2 write.
    assign upd_acc  = o_ready && i_valid && !i_clear;
    assign rd_acc   = o_ready && i_rd_req && !i_valid && !i_clear;
    assign upd_we   = upd_v_q && o_ready && !i_clear && i_rst_n;
    assign clear_we = o_clear_busy;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            bin_in[k] = i_bin[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef HIST_SATURATE_EN
            s2_wdata[k] = (&s2_base_q[k]) ? s2_base_q[k] : s2_base_q[k] + 1'b1;
`else
            s2_wdata[k] = s2_base_q[k] + 1'b1;
`endif
        end
    end

    assign rd_fwd  = upd_we && (s2_bin_q[i_rd_ch] == i_rd_addr);
    assign rd_next = rd_fwd ? s2_wdata[i_rd_ch] : mem[i_rd_ch][i_rd_addr];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (clear_we) begin
                mem[k][sweep_q] <= '0;
            end else if (upd_we) begin
                mem[k][s2_bin_q[k]] <= s2_wdata[k];
            end
        end
    end

    // Stage 1: RAM read, bypassed with the write landing on the same bin this cycle.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            s2_bin_q[k]  <= bin_in[k];
            s2_base_q[k] <= (upd_we && (s2_bin_q[k] == bin_in[k])) ? s2_wdata[k]
                                                                    : mem[k][bin_in[k]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StClear;
            sweep_q    <= '0;
            upd_v_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            upd_v_q    <= upd_acc;
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= rd_next;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_mc_histogram_accum.sv
// Directed self-checking bench for mc_histogram_accum (default widths plus a CNT_WIDTH=4 copy).
module tb_mc_histogram_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        valid;
    logic [15:0] bin;
    logic        rd_req;
    logic [0:0]  rd_ch;
    logic [7:0]  rd_addr;

    logic        ready, rd_valid, clear_busy;
    logic [23:0] rd_data;
    logic        ready4, rd_valid4, clear_busy4;
    logic [3:0]  rd_data4;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    mc_histogram_accum dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_valid      (valid),
        .i_bin        (bin),
        .o_ready      (ready),
        .i_rd_req     (rd_req),
        .i_rd_ch      (rd_ch),
        .i_rd_addr    (rd_addr),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_clear_busy (clear_busy)
    );

    mc_histogram_accum #(.CNT_WIDTH(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_valid      (valid),
        .i_bin        (bin),
        .o_ready      (ready4),
        .i_rd_req     (rd_req),
        .i_rd_ch      (rd_ch),
        .i_rd_addr    (rd_addr),
        .o_rd_valid   (rd_valid4),
        .o_rd_data    (rd_data4),
        .o_clear_busy (clear_busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!(ready && ready4) && n < 1000) begin
            n++;
            tick();
        end
        check(tag, n, 256);
        check({tag, "_w4"}, ready4, 1);
    endtask

    task automatic rd(input string tag, input logic ch, input logic [7:0] addr,
                      input int exp, input int exp4);
        rd_req  = 1'b1;
        rd_ch   = ch;
        rd_addr = addr;
        tick();
        rd_req = 1'b0;
        check({tag, "_vld"}, rd_valid, 1);
        check(tag, rd_data, exp);
        check({tag, "_w4"}, rd_data4, exp4);
        tick();
        check({tag, "_vld_drop"}, rd_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; bin = '0;
        rd_req = 1'b0; rd_ch = '0; rd_addr = '0;
        tick();
        tick();
        check("rst_ready", ready, 0);
        check("rst_busy", clear_busy, 1);
        check("rst_busy_w4", clear_busy4, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        wait_ready("init_sweep");
        check("accum_busy", clear_busy, 0);
        rd("init_rd0", 1'b0, 8'h00, 0, 0);
        rd("init_rd1", 1'b1, 8'hff, 0, 0);

        // Five back-to-back updates on the same bin per channel.
        valid = 1'b1;
        bin   = {8'h20, 8'h10};
        repeat (5) tick();
        valid = 1'b0;
        rd("b2b_ch0", 1'b0, 8'h10, 5, 5);
        rd("b2b_ch1", 1'b1, 8'h20, 5, 5);
        rd("b2b_ch1_other", 1'b1, 8'h10, 0, 0);
        rd("b2b_ch0_other", 1'b0, 8'h20, 0, 0);

        // Alternating bins, read issued the cycle after the last update.
        valid = 1'b1;
        bin = {8'h50, 8'h03}; tick();
        bin = {8'h50, 8'h04}; tick();
        bin = {8'h50, 8'h03}; tick();
        bin = {8'h50, 8'h04}; tick();
        valid = 1'b0;
        rd("alt_bin3", 1'b0, 8'h03, 2, 2);
        rd("alt_bin4", 1'b0, 8'h04, 2, 2);
        rd("alt_ch1", 1'b1, 8'h50, 4, 4);

        // Read in the cycle the increment is written must see it.
        valid = 1'b1;
        bin = {8'h33, 8'h09}; tick();
        valid = 1'b0;
        rd("fwd_rd", 1'b0, 8'h09, 1, 1);

        // Update and read in the same cycle: update wins, read dropped.
        valid = 1'b1; bin = {8'h07, 8'h07};
        rd_req = 1'b1; rd_ch = 1'b0; rd_addr = 8'h07;
        tick();
        valid = 1'b0; rd_req = 1'b0;
        check("collide_no_rd", rd_valid, 0);
        rd("collide_ch0", 1'b0, 8'h07, 1, 1);
        rd("collide_ch1", 1'b1, 8'h07, 1, 1);

        // Saturation / wrap with 17 updates.
        valid = 1'b1; bin = {8'h81, 8'h80};
        repeat (17) tick();
        valid = 1'b0;
`ifdef HIST_SATURATE_EN
        rd("ovf", 1'b0, 8'h80, 17, 15);
`else
        rd("ovf", 1'b0, 8'h80, 17, 1);
`endif

        // Clear mid-flight together with a read request.
        valid = 1'b1; bin = {8'h40, 8'h40}; tick();
        valid = 1'b0; clear = 1'b1; rd_req = 1'b1; rd_ch = 1'b0; rd_addr = 8'h10;
        tick();
        clear = 1'b0; rd_req = 1'b0;
        check("clr_no_rd", rd_valid, 0);
        check("clr_ready", ready, 0);
        check("clr_busy", clear_busy, 1);
        wait_ready("clr_sweep");
        rd("clr_bin10", 1'b0, 8'h10, 0, 0);
        rd("clr_bin20", 1'b1, 8'h20, 0, 0);
        rd("clr_bin40", 1'b0, 8'h40, 0, 0);
        rd("clr_bin80", 1'b0, 8'h80, 0, 0);

        // Reset at sweep index 100 restarts the full sweep.
        valid = 1'b1; bin = {8'h05, 8'h05}; tick();
        valid = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        check("midrst_busy", clear_busy, 1);
        wait_ready("midrst_sweep");
        rd("midrst_bin5", 1'b1, 8'h05, 0, 0);

        // Clear while clearing restarts the sweep.
        clear = 1'b1; tick();
        clear = 1'b0;
        repeat (50) tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        wait_ready("reclr_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
